// File: rtl/als_pkg.sv
// Shared state encoding and default thresholds for the ambient-light monitor.
package als_pkg;

    typedef enum logic {
        S_FILL = 1'b0,
        S_RUN  = 1'b1
    } als_state_t;

    localparam int DEF_SAMPLE_PERIOD = 1000;
    localparam int DEF_WIN_LOG2      = 3;
    localparam int DEF_DARK_ON       = 40;
    localparam int DEF_DARK_OFF      = 60;

endpackage

// File: rtl/als_tick_gen.sv
// Sample-rate strobe: one-cycle tick every PERIOD clocks, first tick PERIOD cycles after reset.
module als_tick_gen
    import als_pkg::*;
#(
    parameter int PERIOD = DEF_SAMPLE_PERIOD
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = $clog2(PERIOD);
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/als_light_monitor.sv
// Moving-average light monitor with bar-graph level and dark flag.
// Define ALS_HYST_EN for a hysteretic dark flag; otherwise dark is a plain threshold.
//
// state  | meaning
// S_FILL | window not yet full, no avg_valid
// S_RUN  | window full, avg/dark refresh one cycle after every tick
module als_light_monitor
    import als_pkg::*;
#(
    parameter int SAMPLE_PERIOD = DEF_SAMPLE_PERIOD,
    parameter int WIN_LOG2      = DEF_WIN_LOG2,
    parameter int DARK_ON       = DEF_DARK_ON,
    parameter int DARK_OFF      = DEF_DARK_OFF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] value,
    output logic [7:0] avg,
    output logic       avg_valid,
    output logic [3:0] level,
    output logic       dark
);

    localparam int WIN = 1 << WIN_LOG2;
    localparam int SW  = 8 + WIN_LOG2;
    // keep the set threshold strictly below the clear threshold even for a misconfigured pair
    localparam logic [7:0] DARK_ON_V  = 8'((DARK_ON < DARK_OFF) ? DARK_ON : DARK_OFF - 1);
    localparam logic [7:0] DARK_OFF_V = 8'(DARK_OFF);
    localparam logic [WIN_LOG2-1:0] WP_LAST = '1;

    logic                tick;
    logic                tick_d;
    logic [7:0]          ring [WIN];
    logic [WIN_LOG2-1:0] wp;
    logic [SW-1:0]       sum;
    als_state_t          state;
    logic [7:0]          avg_new;
    logic                dark_next;

    als_tick_gen #(.PERIOD(SAMPLE_PERIOD)) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    assign avg_new = sum[SW-1:WIN_LOG2];
    assign level   = avg[7:4];

    always_comb begin
        dark_next = dark;
`ifdef ALS_HYST_EN
        if (avg_new <= DARK_ON_V) begin
            dark_next = 1'b1;
        end else if (avg_new >= DARK_OFF_V) begin
            dark_next = 1'b0;
        end
`else
        dark_next = (avg_new <= DARK_ON_V);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_d    <= 1'b0;
            wp        <= '0;
            sum       <= '0;
            state     <= S_FILL;
            avg       <= '0;
            avg_valid <= 1'b0;
            dark      <= 1'b0;
            for (int i = 0; i < WIN; i++) begin
                ring[i] <= '0;
            end
        end else begin
            tick_d    <= tick;
            avg_valid <= 1'b0;

            if (tick) begin
                ring[wp] <= value;
                wp       <= wp + 1'b1;
                // the evicted entry is always part of sum, so this cannot underflow
                sum      <= sum + SW'(value) - SW'(ring[wp]);
                if (state == S_FILL && wp == WP_LAST) begin
                    state <= S_RUN;
                end
            end

            if (tick_d && state == S_RUN) begin
                avg       <= avg_new;
                avg_valid <= 1'b1;
                dark      <= dark_next;
            end
        end
    end

endmodule

// File: tb/tb_als_light_monitor.sv
// Randomized bench for als_light_monitor (period 8, window 8) against a queue-based average model.
module tb_als_light_monitor;

    localparam int PER = 8;
    localparam int WIN = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] value = 8'd0;
    logic [7:0] avg;
    logic       avg_valid;
    logic [3:0] level;
    logic       dark;

    int total = 0;
    int bad   = 0;

    int hist[$];
    int n_samples;
    int exp_avg;
    bit exp_dark;
    int pend_avg;
    bit pend_dark;
    bit pend;

    als_light_monitor #(
        .SAMPLE_PERIOD(PER),
        .WIN_LOG2     (3),
        .DARK_ON      (40),
        .DARK_OFF     (60)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .value     (value),
        .avg       (avg),
        .avg_valid (avg_valid),
        .level     (level),
        .dark      (dark)
    );

    always #5 clk = ~clk;

    // Entered at the negedge opening cycle 0 of a sample period; leaves at the next cycle 0.
    task automatic drive_sample(input logic [7:0] v, input bit toggle);
        int s;
        for (int i = 0; i < PER; i++) begin
            if (i == 1 && pend) begin
                exp_avg  = pend_avg;
                exp_dark = pend_dark;
                pend     = 1'b0;
                total++;
                if (avg_valid !== 1'b1) begin
                    bad++;
                    $display("FAIL avg_valid_pulse t=%0t got=%0b want=1", $time, avg_valid);
                end
            end else begin
                total++;
                if (avg_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL avg_valid_idle t=%0t cyc=%0d got=%0b want=0", $time, i, avg_valid);
                end
            end
            total++;
            if (avg !== exp_avg[7:0]) begin
                bad++;
                $display("FAIL avg t=%0t got=%0d want=%0d", $time, avg, exp_avg);
            end
            total++;
            if (level !== exp_avg[7:4]) begin
                bad++;
                $display("FAIL level t=%0t got=%0d want=%0d", $time, level, exp_avg[7:4]);
            end
            total++;
            if (dark !== exp_dark) begin
                bad++;
                $display("FAIL dark t=%0t got=%0b want=%0b", $time, dark, exp_dark);
            end
            value = (i == PER - 1 || !toggle) ? v : 8'($urandom_range(0, 255));
            @(negedge clk);
        end
        hist.push_back(int'(v));
        if (hist.size() > WIN) void'(hist.pop_front());
        n_samples++;
        if (n_samples >= WIN) begin
            s = 0;
            foreach (hist[k]) s += hist[k];
            pend_avg = s / WIN;
`ifdef ALS_HYST_EN
            if (pend_avg <= 40)      pend_dark = 1'b1;
            else if (pend_avg >= 60) pend_dark = 1'b0;
            else                     pend_dark = exp_dark;
`else
            pend_dark = (pend_avg <= 40);
`endif
            pend = 1'b1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        total++;
        if (avg !== 8'd0 || avg_valid !== 1'b0 || dark !== 1'b0 || level !== 4'd0) begin
            bad++;
            $display("FAIL reset_outputs avg=%0d valid=%0b dark=%0b level=%0d want all 0",
                     avg, avg_valid, dark, level);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        hist.delete();
        n_samples = 0;
        exp_avg   = 0;
        exp_dark  = 1'b0;
        pend      = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_fill();
        do_reset();
        for (int k = 0; k < WIN; k++) drive_sample(8'd100, 1'b0);
        drive_sample(8'd100, 1'b0);
        total++;
        if (avg !== 8'd100 || level !== 4'd6) begin
            bad++;
            $display("FAIL fill avg=%0d level=%0d want 100/6", avg, level);
        end
    endtask

    task automatic test_sliding();
        do_reset();
        for (int k = 0; k < WIN; k++) drive_sample(8'd0, 1'b1);
        for (int k = 1; k <= WIN + 1; k++) begin
            drive_sample(8'd200, 1'b1);
            if (k >= 2) begin
                total++;
                if (avg !== 8'(25 * (k - 1))) begin
                    bad++;
                    $display("FAIL slide step=%0d got=%0d want=%0d", k - 1, avg, 25 * (k - 1));
                end
            end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int k = 0; k < 2 * WIN + 1; k++) drive_sample(8'd255, 1'b0);
        total++;
        if (avg !== 8'd255 || level !== 4'd15) begin
            bad++;
            $display("FAIL saturation avg=%0d level=%0d want 255/15", avg, level);
        end
    endtask

    task automatic test_hysteresis();
        int  lv [5]   = '{70, 40, 50, 59, 60};
`ifdef ALS_HYST_EN
        bit  want [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
`else
        bit  want [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
`endif
        do_reset();
        for (int j = 0; j < 5; j++) begin
            for (int k = 0; k < WIN + 1; k++) drive_sample(8'(lv[j]), 1'b0);
            total++;
            if (avg !== 8'(lv[j]) || dark !== want[j]) begin
                bad++;
                $display("FAIL hyst step=%0d avg=%0d dark=%0b want %0d/%0b",
                         j, avg, dark, lv[j], want[j]);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        for (int k = 0; k < WIN + 2; k++) drive_sample(8'($urandom_range(100, 255)), 1'b1);
        for (int k = 0; k < 3; k++) begin
            value = 8'($urandom_range(0, 255));
            @(negedge clk);
        end
        do_reset();
        for (int k = 0; k < WIN + 1; k++) drive_sample(8'd10, 1'b0);
        total++;
        if (avg !== 8'd10) begin
            bad++;
            $display("FAIL reset_mid_run avg=%0d want=10", avg);
        end
    endtask

    task automatic test_immunity();
        do_reset();
        for (int k = 0; k < WIN + 1; k++) drive_sample(8'd80, 1'b1);
        total++;
        if (avg !== 8'd80) begin
            bad++;
            $display("FAIL immunity avg=%0d want=80", avg);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 40; k++) drive_sample(8'($urandom_range(0, 255)), 1'b1);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_fill();
        test_sliding();
        test_saturation();
        test_hysteresis();
        test_reset_mid_run();
        test_immunity();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
